// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory-subsystem arbitration logic.
package mem_ctrl_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  localparam int PORT_FIFO   = 0;
  localparam int PORT_MASTER = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  typedef struct packed {
    state_t state;
    logic   ptr;
  } dbg_t;

endpackage

// File: rtl/bram_access_arbiter_if.sv
// Requester and BRAM-side signals of the BRAM access arbiter.
// Handshake: a requester holds req/we/addr/wdata stable until gnt is seen high
// in the same cycle; the access is accepted at that clock edge. rd_validX is a
// one-cycle pulse qualifying the shared rd_data for port X.
interface bram_access_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic              rd_valid0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic              rd_valid1;

  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_data;
  logic              bram_rw;
  logic [DATA_W-1:0] bram_out;

  logic [DATA_W-1:0] rd_data;
  logic              busy;

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, bram_out,
    output gnt0, rd_valid0, gnt1, rd_valid1, bram_addr, bram_data, bram_rw,
           rd_data, busy
  );

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, bram_out,
    input  gnt0, rd_valid0, gnt1, rd_valid1, bram_addr, bram_data, bram_rw,
           rd_data, busy
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: one-hot grant, pointer names the preferred port
// and flips to the other port after every grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt,
  output logic       ptr
);

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (advance && (gnt != 2'b00)) begin
      ptr <= gnt[0];
    end
  end

endmodule

// File: rtl/bram_access_arbiter.sv
// Shares one single-port BRAM between the FIFO-drain port (0) and the master
// port (1); accesses are serialized through IDLE -> ISSUE [-> RD_WAIT].
module bram_access_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic                  clk_mem,
  input  logic                  reset,
  bram_access_arbiter_if.slave  bus,
  output dbg_t                  dbg
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t            state, state_n;
  logic [1:0]        arb_req, arb_gnt;
  logic              arb_ptr;
  logic              in_idle;
  logic [CNT_W-1:0]  cnt;
  logic              owner;
  logic [ADDR_W-1:0] bram_addr_q;
  logic [DATA_W-1:0] bram_data_q;
  logic              bram_rw_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid0_q, rd_valid1_q;

  assign in_idle = (state == IDLE) && !reset;

  // Requests are only presented to the picker in IDLE, so gnt can never fire
  // while an access is in flight or during reset.
  assign arb_req = in_idle ? {bus.req1, bus.req0} : 2'b00;

  rr_arb2 u_arb (
    .clk     (clk_mem),
    .reset   (reset),
    .req     (arb_req),
    .advance (in_idle),
    .gnt     (arb_gnt),
    .ptr     (arb_ptr)
  );

  always_ff @(posedge clk_mem) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (arb_gnt != 2'b00) state_n = ISSUE;
      ISSUE:   state_n = bram_rw_q ? IDLE : RD_WAIT;
      RD_WAIT: if (cnt == '0) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_mem) begin
    if (reset) begin
      bram_addr_q <= '0;
      bram_data_q <= '0;
      bram_rw_q   <= 1'b0;
      rd_data_q   <= '0;
      rd_valid0_q <= 1'b0;
      rd_valid1_q <= 1'b0;
      cnt         <= '0;
      owner       <= 1'b0;
    end else begin
      rd_valid0_q <= 1'b0;
      rd_valid1_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (arb_gnt != 2'b00) begin
            owner <= arb_gnt[PORT_MASTER];
            if (arb_gnt[PORT_MASTER]) begin
              bram_rw_q   <= bus.we1;
              bram_addr_q <= bus.addr1;
              bram_data_q <= bus.wdata1;
            end else begin
              bram_rw_q   <= bus.we0;
              bram_addr_q <= bus.addr0;
              bram_data_q <= bus.wdata0;
            end
          end else begin
            bram_rw_q <= 1'b0;
          end
        end
        ISSUE: begin
          bram_rw_q <= 1'b0;
          cnt       <= CNT_W'(RD_LAT - 1);
        end
        RD_WAIT: begin
          if (cnt == '0) begin
            rd_data_q <= bus.bram_out;
            if (owner) rd_valid1_q <= 1'b1;
            else       rd_valid0_q <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: bram_rw_q <= 1'b0;
      endcase
    end
  end

  assign bus.gnt0      = arb_gnt[PORT_FIFO];
  assign bus.gnt1      = arb_gnt[PORT_MASTER];
  assign bus.rd_valid0 = rd_valid0_q;
  assign bus.rd_valid1 = rd_valid1_q;
  assign bus.bram_addr = bram_addr_q;
  assign bus.bram_data = bram_data_q;
  assign bus.bram_rw   = bram_rw_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.busy      = (state != IDLE);

  assign dbg.state = state;
  assign dbg.ptr   = arb_ptr;

endmodule

// File: tb/tb_bram_access_arbiter.sv
// Self-checking bench for bram_access_arbiter with a behavioural BRAM and a
// read-return scoreboard.
module tb_bram_access_arbiter;
  import mem_ctrl_pkg::*;

  localparam int EW = 25;  // {grant cycle[15:0], port, data[7:0]}

  logic clk_mem = 1'b0;
  logic reset   = 1'b1;
  dbg_t dbg;

  bram_access_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  bram_access_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) dut (
    .clk_mem (clk_mem),
    .reset   (reset),
    .bus     (bus),
    .dbg     (dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_mem = ~clk_mem;

  logic [15:0] cyc_cnt = '0;
  always @(posedge clk_mem) cyc_cnt <= cyc_cnt + 16'd1;

  // ---------------- BRAM model (read latency 1) ----------------
  logic [7:0] bram_mem [256];
  always @(posedge clk_mem) begin
    if (bus.bram_rw) bram_mem[bus.bram_addr] <= bus.bram_data;
    bus.bram_out <= bram_mem[bus.bram_addr];
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [7:0]    model_mem [256];
  logic [EW-1:0] exp_q[$];

  always @(negedge clk_mem) begin
    logic [EW-1:0] e;
    logic [15:0]   lat;
    logic          p;
    if (reset) begin
      exp_q.delete();
    end else begin
      if (bus.gnt0 && bus.gnt1) check("gnt_onehot", 32'd1, 32'd0);
      if (bus.gnt0 || bus.gnt1) begin
        p = bus.gnt1;
        if (p ? bus.we1 : bus.we0)
          model_mem[p ? bus.addr1 : bus.addr0] = p ? bus.wdata1 : bus.wdata0;
        else
          exp_q.push_back({cyc_cnt, p, model_mem[p ? bus.addr1 : bus.addr0]});
      end
      if (bus.rd_valid0 || bus.rd_valid1) begin
        if (exp_q.size() == 0) begin
          check("rd_unexpected", 32'd1, 32'd0);
        end else begin
          e   = exp_q.pop_front();
          lat = cyc_cnt - e[24:9];
          check("rd_port", {31'd0, bus.rd_valid1}, {31'd0, e[8]});
          check("rd_one_port", {31'd0, bus.rd_valid0 & bus.rd_valid1}, 32'd0);
          check("rd_data", {24'd0, bus.rd_data}, {24'd0, e[7:0]});
          check("rd_latency", {16'd0, lat}, 32'd3);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk_mem);
    #1;
  endtask

  task automatic drive_req(input int port, input logic r, input logic we,
                           input logic [7:0] addr, input logic [7:0] data);
    if (port == 0) begin
      bus.req0 = r; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = data;
    end else begin
      bus.req1 = r; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = data;
    end
  endtask

  // Returns one cycle after the grant edge (the ISSUE cycle), or after timeout.
  task automatic wait_gnt(input int port);
    bit found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk_mem);
      if (port == 0 ? bus.gnt0 : bus.gnt1) found = 1;
      else cyc();
    end
    if (!found) check("gnt_timeout", 32'd0, 32'd1);
    cyc();
  endtask

  task automatic do_access(input int port, input logic we,
                           input logic [7:0] addr, input logic [7:0] data);
    drive_req(port, 1'b1, we, addr, data);
    wait_gnt(port);
    drive_req(port, 1'b0, we, addr, data);
    @(negedge clk_mem);
    check("issue_rw", {31'd0, bus.bram_rw}, {31'd0, we});
    check("issue_addr", {24'd0, bus.bram_addr}, {24'd0, addr});
    if (we) check("issue_data", {24'd0, bus.bram_data}, {24'd0, data});
    cyc();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 256; i++) begin
      bram_mem[i]  = 8'h00;
      model_mem[i] = 8'h00;
    end
    drive_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive_req(1, 1'b0, 1'b0, 8'h00, 8'h00);

    // Reset held 3 cycles with a pending port 0 write.
    reset = 1'b1;
    drive_req(0, 1'b1, 1'b1, 8'h01, 8'h11);
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge clk_mem);
      check("rst_gnt0", {31'd0, bus.gnt0}, 32'd0);
      check("rst_rw", {31'd0, bus.bram_rw}, 32'd0);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_outs", {bus.rd_data, bus.bram_addr, bus.bram_data,
                         5'd0, bus.rd_valid0, bus.rd_valid1, bus.gnt1}, 32'd0);
      check("rst_state", {30'd0, dbg.state}, {30'd0, IDLE});
    end
    cyc();
    reset = 1'b0;
    @(negedge clk_mem);
    check("first_gnt0", {31'd0, bus.gnt0}, 32'd1);
    check("first_gnt1", {31'd0, bus.gnt1}, 32'd0);
    cyc();
    drive_req(0, 1'b0, 1'b1, 8'h01, 8'h11);
    @(negedge clk_mem);
    check("first_issue_rw", {31'd0, bus.bram_rw}, 32'd1);
    check("first_busy", {31'd0, bus.busy}, 32'd1);
    cyc();

    // Port 1 write then read of 0x10.
    do_access(1, 1'b1, 8'h10, 8'hA5);
    do_access(1, 1'b0, 8'h10, 8'h00);
    @(negedge clk_mem);
    check("rd_early", {31'd0, bus.rd_valid1}, 32'd0);
    cyc();
    @(negedge clk_mem);
    check("rd1_valid", {31'd0, bus.rd_valid1}, 32'd1);
    check("rd1_data", {24'd0, bus.rd_data}, 32'hA5);
    check("rd0_quiet", {31'd0, bus.rd_valid0}, 32'd0);
    cyc();

    // Continuous contention: alternating grants every 2 cycles.
    drive_req(0, 1'b1, 1'b1, 8'h20, 8'h5A);
    drive_req(1, 1'b1, 1'b1, 8'h21, 8'hC3);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_mem);
      check("cont_gnt0", {31'd0, bus.gnt0}, {31'd0, (i % 4) == 0});
      check("cont_gnt1", {31'd0, bus.gnt1}, {31'd0, (i % 4) == 2});
      cyc();
    end
    drive_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
    cyc();

    // Read-after-write on 0xFF with simultaneous requests.
    drive_req(0, 1'b1, 1'b1, 8'hFF, 8'h3C);
    drive_req(1, 1'b1, 1'b0, 8'hFF, 8'h00);
    @(negedge clk_mem);
    check("raw_gnt0", {31'd0, bus.gnt0}, 32'd1);
    check("raw_gnt1", {31'd0, bus.gnt1}, 32'd0);
    cyc();
    drive_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    wait_gnt(1);
    drive_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (4) cyc();

    // Reset during RD_WAIT: read aborted, pointer back to port 0.
    drive_req(0, 1'b1, 1'b0, 8'h10, 8'h00);
    wait_gnt(0);
    drive_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    cyc();
    reset = 1'b1;
    @(negedge clk_mem);
    check("mid_state", {30'd0, dbg.state}, {30'd0, RD_WAIT});
    check("mid_ptr", {31'd0, dbg.ptr}, 32'd1);
    cyc();
    reset = 1'b0;
    @(negedge clk_mem);
    check("abort_state", {30'd0, dbg.state}, {30'd0, IDLE});
    check("abort_ptr", {31'd0, dbg.ptr}, 32'd0);
    check("abort_rw", {31'd0, bus.bram_rw}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_mem);
      check("abort_no_valid", {30'd0, bus.rd_valid0, bus.rd_valid1}, 32'd0);
      cyc();
    end
    drive_req(0, 1'b1, 1'b1, 8'h30, 8'h13);
    drive_req(1, 1'b1, 1'b1, 8'h31, 8'h14);
    @(negedge clk_mem);
    check("post_rst_gnt0", {31'd0, bus.gnt0}, 32'd1);
    cyc();
    drive_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    wait_gnt(1);
    drive_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
    cyc();

    // Withdrawn port 1 request while a port 0 write is in ISSUE.
    drive_req(0, 1'b1, 1'b1, 8'h44, 8'h99);
    wait_gnt(0);
    drive_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive_req(1, 1'b1, 1'b1, 8'h55, 8'h77);
    @(negedge clk_mem);
    check("wd_gnt1_issue", {31'd0, bus.gnt1}, 32'd0);
    cyc();
    drive_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_mem);
      check("wd_gnt1", {31'd0, bus.gnt1}, 32'd0);
      check("wd_rw", {31'd0, bus.bram_rw}, 32'd0);
      cyc();
    end
    do_access(0, 1'b0, 8'h55, 8'h00);
    repeat (3) cyc();

    // Random single-port traffic over a small address window.
    for (int i = 0; i < 16; i++) begin
      do_access(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                8'h80 + 8'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc();
    check("drain", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
